// File: rtl/factor_game_ctrl.sv
// rtl/factor_game_ctrl.sv - factorization quiz sequencer: phase timing, question LFSR, answer judging, score
module factor_game_ctrl #(
    parameter int READY_CYC = 50_000_000,
    parameter int QUE_CYC   = 100_000_000,
    parameter int INPUT_CYC = 250_000_000,
    parameter int NUM_Q     = 5,
    parameter int TW        = 28
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       START,
    input  logic       ENTER,
    input  logic [3:0] SW_DIN,
    output logic [3:0] STATE,
    output logic [3:0] QUE,
    output logic [3:0] DIN,
    output logic [3:0] SCORE
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0000,
        S_READY    = 4'b0010,
        S_QUESTION = 4'b0011,
        S_INPUT    = 4'b0100,
        S_CLEAR    = 4'b0111,
        S_FAIL     = 4'b1000
    } state_t;

    state_t        state, next_state;
    logic          start_prev, enter_prev;
    logic          start_rise, enter_rise;
    logic [TW-1:0] timer;
    logic [3:0]    qcnt;
    logic [3:0]    lfsr;
    logic          correct;
    logic          last_q;

    function automatic logic [3:0] smallest_prime(input logic [3:0] q);
        case (q)
            4'd2, 4'd4, 4'd6, 4'd8: smallest_prime = 4'd2;
            4'd3, 4'd9:             smallest_prime = 4'd3;
            4'd5:                   smallest_prime = 4'd5;
            4'd7:                   smallest_prime = 4'd7;
            default:                smallest_prime = 4'd0;
        endcase
    endfunction

    assign start_rise = START & ~start_prev;
    assign enter_rise = ENTER & ~enter_prev;
    assign correct    = (SW_DIN == smallest_prime(QUE));
    assign last_q     = (qcnt == 4'(NUM_Q - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ENTER is checked before the timeout so a rise on the final INPUT cycle is judged
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start_rise) next_state = S_READY;
            S_READY:    if (timer == TW'(READY_CYC - 1)) next_state = S_QUESTION;
            S_QUESTION: if (timer == TW'(QUE_CYC - 1)) next_state = S_INPUT;
            S_INPUT: begin
                if (enter_rise) begin
                    if (!correct)    next_state = S_FAIL;
                    else if (last_q) next_state = S_CLEAR;
                    else             next_state = S_READY;
                end else if (timer == TW'(INPUT_CYC - 1)) begin
                    next_state = S_FAIL;
                end
            end
            S_CLEAR, S_FAIL: if (start_rise) next_state = S_READY;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        STATE = state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            start_prev <= 1'b0;
            enter_prev <= 1'b0;
            timer      <= '0;
            lfsr       <= 4'b0001;
            qcnt       <= 4'd0;
            QUE        <= 4'd0;
            DIN        <= 4'd0;
            SCORE      <= 4'd0;
        end else begin
            start_prev <= START;
            enter_prev <= ENTER;
            DIN        <= SW_DIN;
            lfsr       <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            timer      <= (next_state != state) ? '0 : timer + TW'(1);
            if (state == S_READY && next_state == S_QUESTION) begin
                QUE <= {1'b0, lfsr[2:0]} + 4'd2;
            end
            if (state == S_INPUT && enter_rise && correct) begin
                SCORE <= SCORE + 4'd1;
                if (!last_q) qcnt <= qcnt + 4'd1;
            end
            if ((state == S_CLEAR || state == S_FAIL) && start_rise) begin
                SCORE <= 4'd0;
                qcnt  <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_factor_game_ctrl.sv
// tb/tb_factor_game_ctrl.sv - directed scoreboard bench for factor_game_ctrl
module tb_factor_game_ctrl;

    localparam logic [3:0] IDLE = 4'b0000, READY = 4'b0010, QUESTION = 4'b0011,
                           INPUT = 4'b0100, CLEAR = 4'b0111, FAILS = 4'b1000;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       START = 1'b0;
    logic       ENTER = 1'b0;
    logic [3:0] SW_DIN = 4'd0;
    logic [3:0] STATE, QUE, DIN, SCORE;

    factor_game_ctrl #(
        .READY_CYC(4), .QUE_CYC(3), .INPUT_CYC(10), .NUM_Q(2), .TW(8)
    ) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .ENTER(ENTER), .SW_DIN(SW_DIN),
        .STATE(STATE), .QUE(QUE), .DIN(DIN), .SCORE(SCORE)
    );

    always #5 CLK = ~CLK;

    // Reference question source: x^4+x^3+1, seed 0001, steps every cycle out of reset
    logic [3:0] m_lfsr = 4'b0001;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m_lfsr <= 4'b0001;
        else       m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [3:0] spf(input logic [3:0] q);
        if (q % 2 == 0) return 4'd2;
        if (q % 3 == 0) return 4'd3;
        return q;
    endfunction

    task automatic push(input string tag, input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [3:0] obs);
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [3:0] sc,
                        input bit cq, input logic [3:0] qv);
        push({tag, "_state"}, st);
        push({tag, "_score"}, sc);
        if (cq) push({tag, "_que"}, qv);
        tick();
        pop_check(STATE);
        pop_check(SCORE);
        if (cq) pop_check(QUE);
    endtask

    task automatic start_pulse(input string tag);
        START = 1'b1;
        step(tag, READY, 4'd0, 1'b0, 4'd0);
        START = 1'b0;
    endtask

    // From the first READY cycle to the first INPUT cycle; START pulsed mid-QUESTION
    task automatic go_input(input string tag, input logic [3:0] sc, output logic [3:0] q);
        for (int i = 0; i < 3; i++) step({tag, "_ready"}, READY, sc, 1'b0, 4'd0);
        q = {1'b0, m_lfsr[2:0]} + 4'd2;
        step({tag, "_question"}, QUESTION, sc, 1'b1, q);
        START = 1'b1;
        step({tag, "_q_start_ignored"}, QUESTION, sc, 1'b1, q);
        START = 1'b0;
        step({tag, "_question"}, QUESTION, sc, 1'b1, q);
        step({tag, "_input"}, INPUT, sc, 1'b1, q);
    endtask

    task automatic answer(input string tag, input logic [3:0] sw,
                          input logic [3:0] st, input logic [3:0] sc);
        SW_DIN = sw;
        ENTER  = 1'b1;
        step(tag, st, sc, 1'b0, 4'd0);
        ENTER  = 1'b0;
    endtask

    logic [3:0] q;

    initial begin
        // Reset and idle
        for (int i = 0; i < 3; i++) step("reset", IDLE, 4'd0, 1'b1, 4'd0);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) step("idle", IDLE, 4'd0, 1'b1, 4'd0);
        SW_DIN = 4'd5;
        push("din_5", 4'd5);
        tick();
        pop_check(DIN);
        SW_DIN = 4'd12;
        push("din_12", 4'd12);
        tick();
        pop_check(DIN);
        ENTER = 1'b1;
        step("idle_enter_ignored", IDLE, 4'd0, 1'b0, 4'd0);
        ENTER = 1'b0;

        // Full correct round
        start_pulse("start1");
        go_input("r1q1", 4'd0, q);
        answer("r1q1_correct", spf(q), READY, 4'd1);
        go_input("r1q2", 4'd1, q);
        answer("r1q2_correct", spf(q), CLEAR, 4'd2);
        step("clear_hold", CLEAR, 4'd2, 1'b0, 4'd0);

        // New round: correct, then wrong answer with ENTER held
        start_pulse("start2");
        go_input("r2q1", 4'd0, q);
        answer("r2q1_correct", spf(q), READY, 4'd1);
        go_input("r2q2", 4'd1, q);
        SW_DIN = spf(q) ^ 4'd1;
        ENTER  = 1'b1;
        for (int i = 0; i < 5; i++) step("held_wrong", FAILS, 4'd1, 1'b0, 4'd0);
        ENTER  = 1'b0;
        step("fail_hold", FAILS, 4'd1, 1'b0, 4'd0);

        // START from FAIL, then timeout
        start_pulse("start_from_fail");
        go_input("r3q1", 4'd0, q);
        for (int i = 0; i < 9; i++) step("timeout_wait", INPUT, 4'd0, 1'b0, 4'd0);
        step("timeout_fail", FAILS, 4'd0, 1'b0, 4'd0);

        // ENTER on the final INPUT cycle wins over timeout
        start_pulse("start4");
        go_input("r4q1", 4'd0, q);
        for (int i = 0; i < 9; i++) step("tie_wait", INPUT, 4'd0, 1'b0, 4'd0);
        answer("tie_enter_wins", spf(q), READY, 4'd1);

        // Asynchronous reset during INPUT with SCORE=1
        go_input("r4q2", 4'd1, q);
        #2;
        nRST = 1'b0;
        #1;
        push("async_state", IDLE);
        push("async_score", 4'd0);
        push("async_que", 4'd0);
        pop_check(STATE);
        pop_check(SCORE);
        pop_check(QUE);
        tick();
        nRST = 1'b1;
        step("post_reset", IDLE, 4'd0, 1'b1, 4'd0);
        start_pulse("start5");
        go_input("r5q1", 4'd0, q);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/factor_game_ctrl.md
# factor_game_ctrl

Sequencing controller for the factorization quiz. It steps the game through its states and presents the 4-bit state code, the question digit and the player digit to the downstream 7-segment decoder. It also times each phase, judges the player's answer and keeps the score. It sits between the board pushbuttons/switches and the display decoder.

## Interface
Parameters:
- READY_CYC, 50_000_000: cycles spent in READY before each question.
- QUE_CYC, 100_000_000: cycles the question digit is shown.
- INPUT_CYC, 250_000_000: answer timeout, in cycles.
- NUM_Q, 5: questions per round (1..15).
- TW, 28: width of the phase timer; must hold the largest *_CYC.

Ports:
- CLK, in, 1: system clock. All logic is on the rising edge.
- nRST, in, 1: asynchronous, active-low reset.
- START, in, 1: start button. Active-high, already synchronized to CLK.
- ENTER, in, 1: answer-submit button. Active-high, already synchronized.
- SW_DIN, in, 4: player answer switches.
- STATE, out, 4: state code to the decoder.
- QUE, out, 4: current question digit.
- DIN, out, 4: registered copy of SW_DIN.
- SCORE, out, 4: correct answers in the current round.

## Operation
- Edge detect: START and ENTER are each registered once, and rise = in & ~prev. Only rising edges act on state.
- State codes:
  - IDLE 4'b0000
  - READY 4'b0010
  - QUESTION 4'b0011
  - INPUT 4'b0100
  - CLEAR 4'b0111
  - FAIL 4'b1000
- Transitions:
  - IDLE: START rise -> READY.
  - READY: lasts READY_CYC cycles -> QUESTION.
  - QUESTION: lasts QUE_CYC cycles -> INPUT.
  - INPUT, correct answer on ENTER rise: SCORE+1. Then go to CLEAR if this was question NUM_Q-1, otherwise READY with qcnt+1.
  - INPUT, wrong answer on ENTER rise, or timeout after INPUT_CYC cycles with no ENTER rise: -> FAIL.
  - CLEAR/FAIL: STATE holds. START rise -> READY with SCORE=0 and qcnt=0.
- Question generator:
  - 4-bit LFSR, x^4+x^3+1, seed 4'b0001, advances every cycle, never all-zero.
  - On the READY->QUESTION transition, QUE <= {1'b0, lfsr[2:0]} + 2, giving a value in 2..9.
  - QUE holds until the next such transition.
- Judging: the answer is correct when SW_DIN, sampled on the ENTER-rise cycle, equals the smallest prime factor of QUE:
  - 2 for QUE = 2, 4, 6, 8
  - 3 for QUE = 3, 9
  - 5 for QUE = 5
  - 7 for QUE = 7
- DIN <= SW_DIN every cycle, in every state.
- START in READY, QUESTION or INPUT is ignored. ENTER outside INPUT is ignored.
- SCORE does not wrap; with NUM_Q ≤ 15 it never overflows.

## Timing
- Reset values: STATE=0000, QUE=0, DIN=0, SCORE=0, qcnt=0, timer=0, LFSR=0001, edge registers=0.
- The timer clears on every state change and counts up.
- A timed state exits on the cycle where timer == CYC-1, so it lasts exactly CYC cycles.
- START high at cycle n (having been low at n-1): STATE shows READY at n+1.
- QUE updates in the same cycle STATE becomes QUESTION.
- DIN latency is 1 cycle.
- ENTER rise and INPUT timeout in the same cycle: ENTER wins and is judged.
- ENTER held high counts once; a new rise needs ENTER low for at least 1 cycle.
- nRST asserted in any state forces reset values immediately, with no clock needed. Release is synchronous to the next CLK edge.

## Test plan
Parameters for all scenarios: READY_CYC=4, QUE_CYC=3, INPUT_CYC=10, NUM_Q=2.
- Reset/idle: hold nRST low, then release, with START low for 20 cycles -> STATE=0000, QUE=0, SCORE=0 throughout.
- Correct round: START pulse -> READY for 4 cycles, QUESTION for 3 cycles with QUE in 2..9. In INPUT, drive SW_DIN with the smallest prime factor of QUE and pulse ENTER -> READY with SCORE=1. Repeat for the second question -> CLEAR (0111), SCORE=2.
- Wrong answer: QUE=9, SW_DIN=9, ENTER pulse -> FAIL (1000) next cycle, SCORE unchanged.
- Timeout and tie:
  - No ENTER for 10 INPUT cycles -> FAIL.
  - Separate run: correct ENTER rise on the 10th INPUT cycle -> READY, not FAIL.
- Ignored inputs:
  - ENTER held high for 5 cycles in INPUT with a wrong SW_DIN -> exactly one FAIL transition.
  - START pulses during QUESTION -> no effect.
  - START in FAIL -> READY with SCORE=0.
- Reset mid-operation: assert nRST during INPUT with SCORE=1 -> STATE=0000, SCORE=0, QUE=0 asynchronously, before the next CLK edge.
